sipo_word_receiver: RTL
=======================

SIPO_WORD_RECEIVER -- requirements
Module: sipo_word_receiver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of bits per word (legal range 2..16).
REQ-002 The block SHALL have parameter MSB_FIRST, default 0; 0 means the first received bit is word bit 0, 1 means the first received bit is word bit WIDTH-1.
REQ-003 The block SHALL have port i_clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_d, input, 1 bit: serial data from the upstream parallel-in/serial-out stage.
REQ-006 The block SHALL have port i_shift, input, 1 bit: bit strobe; i_d is sampled only on edges where i_shift=1.
REQ-007 The block SHALL have port i_clear, input, 1 bit: synchronous abort of any partial word and clear of o_overrun.
REQ-008 The block SHALL have port i_ready, input, 1 bit: the consumer accepts the held word.
REQ-009 The block SHALL have port o_q, output, WIDTH bits: the assembled word in the holding register.
REQ-010 The block SHALL have port o_valid, output, 1 bit: o_q holds an unconsumed word.
REQ-011 The block SHALL have port o_overrun, output, 1 bit: sticky flag, a completed word was dropped.
REQ-012 The block SHALL have port o_bit_cnt, output, clog2(WIDTH+1) bits: number of bits collected in the current partial word.

Function
REQ-013 The block SHALL implement two states: IDLE (o_bit_cnt=0) and RECV (0<o_bit_cnt<WIDTH).
- IDLE -> RECV on i_shift=1.
- RECV -> IDLE when the WIDTH-th bit is sampled, or on i_clear=1.
REQ-014 Each sampled bit SHALL enter an internal shift register at a position set by MSB_FIRST, and o_bit_cnt SHALL increment by 1.
REQ-015 On the edge sampling the WIDTH-th bit, the full word (including that bit) SHALL transfer to the holding register, o_bit_cnt SHALL return to 0, and o_valid SHALL be 1 after that same edge (zero-cycle latency after the last bit).
REQ-016 A handshake SHALL complete on any edge with o_valid=1 and i_ready=1; o_valid SHALL then clear unless a new word completes on that same edge.
REQ-017 While o_valid=1 and i_ready=0, o_q SHALL remain stable.
REQ-018 Word completion on the same edge as a handshake SHALL load the new word, keep o_valid=1, and leave o_overrun unchanged.
REQ-019 Word completion while o_valid=1 and i_ready=0 SHALL discard the new word, keep the old o_q, and set o_overrun=1.
REQ-020 o_overrun SHALL stay 1 until i_clear=1 or reset.
REQ-021 i_clear=1 SHALL zero o_bit_cnt and the partial shift register, clear o_overrun, and take priority over a simultaneous i_shift; it SHALL NOT affect o_q, o_valid, or a simultaneous handshake.
REQ-022 i_ready while o_valid=0 SHALL have no effect.
REQ-023 Back-to-back i_shift on every cycle SHALL be supported with no lost bits: a word completes every WIDTH cycles.

Reset
REQ-024 i_rst=0 SHALL immediately, without waiting for a clock edge, force o_q=0, o_valid=0, o_overrun=0, o_bit_cnt=0, the shift register to 0, and state IDLE.
REQ-025 Assertion of reset mid-word SHALL discard the partial word; after release, reception SHALL restart at bit 0.
REQ-026 The first rising i_clk edge after i_rst returns to 1 SHALL be a normal functional edge.

Verification
REQ-027 Scenario 1 (WIDTH=4, MSB_FIRST=0, i_ready=0): shift bits 1,0,1,1 -> o_q=4'b1101, o_valid=1 after the 4th edge, o_bit_cnt=0.
REQ-028 Scenario 2 (MSB_FIRST=1): shift bits 1,0,0,0 -> o_q=4'b1000.
REQ-029 Scenario 3: hold o_valid=1 with i_ready=0 and complete a second word 0x3 -> o_q unchanged, o_overrun=1; then pulse i_clear -> o_overrun=0.
REQ-030 Scenario 4: continuous i_shift with i_ready pulsed on the edge the next word completes -> words 0x5 and 0xA delivered in order, o_valid stays 1, no overrun.
REQ-031 Scenario 5: after 2 bits, assert i_rst=0 between clock edges -> all outputs 0 at once; after release, shift 0xF -> o_q=0xF.
REQ-032 Scenario 6: i_clear with i_shift after 3 bits -> o_bit_cnt=0 and the next 4 bits form a fresh word.

Source files
------------

// File: rtl/sipo_word_receiver.sv
// Serial-in/parallel-out word receiver: collects WIDTH strobed bits into a word,
// hands it off through a valid/ready holding register and flags dropped words.
module sipo_word_receiver #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_d,
  input  logic                           i_shift,
  input  logic                           i_clear,
  input  logic                           i_ready,
  output logic [WIDTH-1:0]               o_q,
  output logic                           o_valid,
  output logic                           o_overrun,
  output logic [$clog2(WIDTH+1)-1:0]     o_bit_cnt
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [WIDTH-1:0]  shifted;
  logic [WIDTH-1:0]  q_q;
  logic              valid_q;
  logic              overrun_q;
  logic              complete;
  logic              handshake;

  // The shifted value is also the finished word on the last bit's edge.
  always_comb begin
    shifted = sr_q;
    if (MSB_FIRST != 0) shifted = {sr_q[WIDTH-2:0], i_d};
    else                shifted = {i_d, sr_q[WIDTH-1:1]};
  end

  assign complete  = i_shift && !i_clear && (state_q == RECV) && (cnt_q == LAST);
  assign handshake = valid_q && i_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    if (i_clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      sr_d    = '0;
    end else if (i_shift) begin
      unique case (state_q)
        IDLE: begin
          state_d = RECV;
          cnt_d   = cnt_q + CW'(1);
          sr_d    = shifted;
        end
        RECV: begin
          if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            sr_d    = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
            sr_d  = shifted;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  // Holding register: a finished word is kept only if the slot is free or
  // being emptied on this same edge; otherwise it is dropped and flagged.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      q_q       <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (complete && (!valid_q || i_ready)) begin
        q_q     <= shifted;
        valid_q <= 1'b1;
      end else if (handshake) begin
        valid_q <= 1'b0;
      end
      if (i_clear)                          overrun_q <= 1'b0;
      else if (complete && valid_q && !i_ready) overrun_q <= 1'b1;
    end
  end

  assign o_q       = q_q;
  assign o_valid   = valid_q;
  assign o_overrun = overrun_q;
  assign o_bit_cnt = cnt_q;

endmodule
